// File: rtl/wb_arb2_rr.sv
// Two-master Wishbone round-robin arbiter; grant is issued one cycle after a request is seen in IDLE.
// The owner keeps the bus until it drops cyc; a slave stall longer than TIMEOUT returns err to the owner.
module wb_arb2_rr #(
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic        clk,
   input  logic        reset,

   input  logic [31:0] m0_adr_i,
   input  logic [31:0] m0_dat_i,
   output logic [31:0] m0_dat_o,
   input  logic [3:0]  m0_sel_i,
   input  logic        m0_we_i,
   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   output logic        m0_ack_o,
   output logic        m0_err_o,

   input  logic [31:0] m1_adr_i,
   input  logic [31:0] m1_dat_i,
   output logic [31:0] m1_dat_o,
   input  logic [3:0]  m1_sel_i,
   input  logic        m1_we_i,
   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   output logic        m1_ack_o,
   output logic        m1_err_o,

   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   output logic [3:0]  s_sel_o,
   output logic        s_we_o,
   output logic        s_cyc_o,
   output logic        s_stb_o,
   input  logic [31:0] s_dat_i,
   input  logic        s_ack_i,
   input  logic        s_err_i,

   output logic [1:0]  grant_o
);

   localparam logic [15:0] TO_VAL = 16'(TIMEOUT);
   localparam bit          TO_EN  = (TIMEOUT != 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t      state_q;
   logic        last_owner_q;
   logic [15:0] stall_q;

   logic        is_g0;
   logic        is_g1;
   logic        own_cyc;
   logic        own_stb;
   logic        timeout_hit;

   assign is_g0 = (state_q == GNT0);
   assign is_g1 = (state_q == GNT1);

   // Only the owner's request fields ever reach the slave; IDLE drives all zeros.
   always_comb begin
      s_adr_o = '0;
      s_dat_o = '0;
      s_sel_o = '0;
      s_we_o  = 1'b0;
      own_cyc = 1'b0;
      own_stb = 1'b0;
      unique case (state_q)
         GNT0: begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_sel_o = m0_sel_i;
            s_we_o  = m0_we_i;
            own_cyc = m0_cyc_i;
            own_stb = m0_stb_i;
         end
         GNT1: begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
            s_we_o  = m1_we_i;
            own_cyc = m1_cyc_i;
            own_stb = m1_stb_i;
         end
         default: begin
         end
      endcase
   end

   // A real ack/err on the limit cycle wins over the timeout.
   assign timeout_hit = TO_EN && (state_q != IDLE) && own_stb && (stall_q == TO_VAL)
                        && !s_ack_i && !s_err_i;

   assign s_cyc_o  = own_cyc & ~timeout_hit;
   assign s_stb_o  = own_stb & ~timeout_hit;

   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;
   assign m0_ack_o = is_g0 & s_ack_i;
   assign m1_ack_o = is_g1 & s_ack_i;
   assign m0_err_o = is_g0 & (s_err_i | timeout_hit);
   assign m1_err_o = is_g1 & (s_err_i | timeout_hit);

   assign grant_o  = {is_g1, is_g0};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         last_owner_q <= 1'b1;
         stall_q      <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               stall_q <= '0;
               if (m0_cyc_i && m1_cyc_i) begin
                  state_q <= last_owner_q ? GNT0 : GNT1;
               end else if (m0_cyc_i) begin
                  state_q <= GNT0;
               end else if (m1_cyc_i) begin
                  state_q <= GNT1;
               end
            end
            GNT0, GNT1: begin
               // Release always passes through IDLE, giving the mandatory dead cycle.
               if (timeout_hit || !own_cyc) begin
                  state_q      <= IDLE;
                  last_owner_q <= is_g1;
                  stall_q      <= '0;
               end else if (s_ack_i || s_err_i) begin
                  stall_q <= '0;
               end else if (own_stb && (stall_q != 16'hFFFF)) begin
                  stall_q <= stall_q + 16'd1;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_arb2_rr.sv
// Directed bench for wb_arb2_rr: per-cycle vector table plus timeout, reset and ack-vs-timeout sequences.
module tb_wb_arb2_rr;
   localparam int unsigned TO = 8;

   localparam logic [31:0] A0 = 32'h4000_0010;
   localparam logic [31:0] D0 = 32'hDEAD_BEEF;
   localparam logic [3:0]  S0 = 4'b0011;
   localparam logic [31:0] A1 = 32'h8000_0200;
   localparam logic [31:0] D1 = 32'h1234_5678;
   localparam logic [3:0]  S1 = 4'b1100;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o, m1_adr_i, m1_dat_i, m1_dat_o;
   logic [3:0]  m0_sel_i, m1_sel_i;
   logic        m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o, m0_err_o;
   logic        m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o, m1_err_o;
   logic [31:0] s_adr_o, s_dat_o, s_dat_i;
   logic [3:0]  s_sel_o;
   logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i;
   logic [1:0]  grant_o;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] sd;

   always #5 clk = ~clk;

   wb_arb2_rr #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_sel_i(m0_sel_i),
      .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
      .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
      .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_sel_i(m1_sel_i),
      .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
      .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i),
      .s_ack_i(s_ack_i), .s_err_i(s_err_i),
      .grant_o(grant_o)
   );

   // ae = {m0_ack, m1_ack, m0_err, m1_err}
   typedef struct packed {
      logic       c0, s0, c1, s1, ack, err;
      logic [1:0] g;
      logic       scyc, sstb;
      logic [3:0] ae;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic [5:0] in, input logic [1:0] g,
                               input logic scyc, input logic sstb, input logic [3:0] ae);
      vec_t v;
      {v.c0, v.s0, v.c1, v.s1, v.ack, v.err} = in;
      v.g    = g;
      v.scyc = scyc;
      v.sstb = sstb;
      v.ae   = ae;
      return v;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic c0, input logic s0, input logic c1, input logic s1,
                        input logic ack, input logic err);
      m0_cyc_i = c0;
      m0_stb_i = s0;
      m1_cyc_i = c1;
      m1_stb_i = s1;
      s_ack_i  = ack;
      s_err_i  = err;
      sd       = $urandom;
      s_dat_i  = sd;
   endtask

   task automatic check_outs(input string tag, input logic [1:0] g, input logic scyc,
                             input logic sstb, input logic [3:0] ae);
      logic [68:0] bus_exp;
      #2;
      case (g)
         2'b01:   bus_exp = {A0, D0, S0, 1'b1};
         2'b10:   bus_exp = {A1, D1, S1, 1'b0};
         default: bus_exp = '0;
      endcase
      chk({tag, ".grant"}, 128'(grant_o), 128'(g));
      chk({tag, ".s_cyc"}, 128'(s_cyc_o), 128'(scyc));
      chk({tag, ".s_stb"}, 128'(s_stb_o), 128'(sstb));
      chk({tag, ".ack_err"}, 128'({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}), 128'(ae));
      chk({tag, ".s_bus"}, 128'({s_adr_o, s_dat_o, s_sel_o, s_we_o}), 128'(bus_exp));
      chk({tag, ".m_dat"}, 128'({m0_dat_o, m1_dat_o}), 128'({sd, sd}));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Each row is one cycle; state carries from row to row.
      tbl.push_back(mk(6'b0000_00, 2'b00, 0, 0, 4'b0000)); // 0 reset state
      tbl.push_back(mk(6'b1111_00, 2'b00, 0, 0, 4'b0000)); // 1 tie, m0 wins first
      tbl.push_back(mk(6'b1111_10, 2'b01, 1, 1, 4'b1000)); // 2
      tbl.push_back(mk(6'b0011_00, 2'b01, 0, 0, 4'b0000)); // 3 m0 drops cyc
      tbl.push_back(mk(6'b0011_10, 2'b00, 0, 0, 4'b0000)); // 4 dead cycle, ack not forwarded
      tbl.push_back(mk(6'b0011_10, 2'b10, 1, 1, 4'b0100)); // 5
      tbl.push_back(mk(6'b0000_00, 2'b10, 0, 0, 4'b0000)); // 6
      tbl.push_back(mk(6'b0000_00, 2'b00, 0, 0, 4'b0000)); // 7
      tbl.push_back(mk(6'b1111_00, 2'b00, 0, 0, 4'b0000)); // 8 tie, last owner m1
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(6'b1111_10, 2'b01, 1, 1, 4'b1000)); // 9..12 four m0 beats
      tbl.push_back(mk(6'b0011_00, 2'b01, 0, 0, 4'b0000)); // 13
      tbl.push_back(mk(6'b0011_00, 2'b00, 0, 0, 4'b0000)); // 14
      tbl.push_back(mk(6'b0011_10, 2'b10, 1, 1, 4'b0100)); // 15
      tbl.push_back(mk(6'b0000_00, 2'b10, 0, 0, 4'b0000)); // 16
      tbl.push_back(mk(6'b0000_00, 2'b00, 0, 0, 4'b0000)); // 17
      tbl.push_back(mk(6'b1100_00, 2'b00, 0, 0, 4'b0000)); // 18
      tbl.push_back(mk(6'b1100_01, 2'b01, 1, 1, 4'b0010)); // 19 slave err forwarded
      tbl.push_back(mk(6'b0000_00, 2'b01, 0, 0, 4'b0000)); // 20
      tbl.push_back(mk(6'b1111_00, 2'b00, 0, 0, 4'b0000)); // 21 tie, last owner m0
      tbl.push_back(mk(6'b1111_10, 2'b10, 1, 1, 4'b0100)); // 22
      tbl.push_back(mk(6'b1100_00, 2'b10, 0, 0, 4'b0000)); // 23
      tbl.push_back(mk(6'b0000_00, 2'b00, 0, 0, 4'b0000)); // 24

      m0_adr_i = A0; m0_dat_i = D0; m0_sel_i = S0; m0_we_i = 1'b1;
      m1_adr_i = A1; m1_dat_i = D1; m1_sel_i = S1; m1_we_i = 1'b0;
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      foreach (tbl[i]) begin
         drive(tbl[i].c0, tbl[i].s0, tbl[i].c1, tbl[i].s1, tbl[i].ack, tbl[i].err);
         check_outs($sformatf("row%0d", i), tbl[i].g, tbl[i].scyc, tbl[i].sstb, tbl[i].ae);
         step();
      end

      // Timeout on m1: err on the cycle the stall count equals TO.
      drive(0, 0, 1, 1, 0, 0);
      check_outs("to.req", 2'b00, 0, 0, 4'b0000);
      step();
      for (int k = 0; k <= int'(TO); k++) begin
         drive(0, 0, 1, 1, 0, 0);
         if (k < int'(TO))
            check_outs($sformatf("to.stall%0d", k), 2'b10, 1, 1, 4'b0000);
         else
            check_outs("to.hit", 2'b10, 0, 0, 4'b0001);
         step();
      end
      // m1 still holds cyc, but m0 requests too and wins re-arbitration.
      drive(1, 1, 1, 1, 0, 0);
      check_outs("to.idle", 2'b00, 0, 0, 4'b0000);
      step();
      drive(1, 1, 1, 1, 1, 0);
      check_outs("to.rearb", 2'b01, 1, 1, 4'b1000);
      step();
      drive(0, 0, 1, 1, 0, 0);
      check_outs("to.m0rel", 2'b01, 0, 0, 4'b0000);
      step();
      drive(0, 0, 1, 1, 0, 0);
      check_outs("rst.idle", 2'b00, 0, 0, 4'b0000);
      step();

      // Reset mid m1 transfer; last owner was m0, so a post-reset tie proves the reset value.
      drive(0, 0, 1, 1, 1, 0);
      check_outs("rst.gnt1", 2'b10, 1, 1, 4'b0100);
      step();
      drive(0, 0, 1, 1, 0, 0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      drive(1, 1, 1, 1, 1, 1);
      check_outs("rst.after", 2'b00, 0, 0, 4'b0000);
      step();
      drive(1, 1, 1, 1, 1, 0);
      check_outs("rst.tie", 2'b01, 1, 1, 4'b1000);
      step();
      drive(0, 0, 0, 0, 0, 0);
      check_outs("rst.rel", 2'b01, 0, 0, 4'b0000);
      step();
      drive(0, 0, 0, 0, 0, 0);
      check_outs("ack.idle0", 2'b00, 0, 0, 4'b0000);
      step();

      // Ack lands on the timeout cycle: ack wins and the count restarts.
      drive(1, 1, 0, 0, 0, 0);
      check_outs("ack.req", 2'b00, 0, 0, 4'b0000);
      step();
      for (int k = 0; k < int'(TO); k++) begin
         drive(1, 1, 0, 0, 0, 0);
         check_outs($sformatf("ack.stall%0d", k), 2'b01, 1, 1, 4'b0000);
         step();
      end
      drive(1, 1, 0, 0, 1, 0);
      check_outs("ack.vs_to", 2'b01, 1, 1, 4'b1000);
      step();
      for (int k = 0; k <= int'(TO); k++) begin
         drive(1, 1, 0, 0, 0, 0);
         if (k < int'(TO))
            check_outs($sformatf("ack.restall%0d", k), 2'b01, 1, 1, 4'b0000);
         else
            check_outs("ack.to2", 2'b01, 0, 0, 4'b0010);
         step();
      end
      drive(0, 0, 0, 0, 0, 0);
      check_outs("ack.idle1", 2'b00, 0, 0, 4'b0000);
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_arb2_rr.md
WB_ARB2_RR -- requirements
Module: wb_arb2_rr

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 1023, giving the stall-cycle limit before a forced error; a value of 0 SHALL disable the timeout.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-004 The block SHALL have ports mN_adr_i (N=0,1), input, 32 bits: master N address.
REQ-005 The block SHALL have ports mN_dat_i, input, 32 bits: master N write data.
REQ-006 The block SHALL have ports mN_dat_o, output, 32 bits: master N read data.
REQ-007 The block SHALL have ports mN_sel_i, input, 4 bits: master N byte selects.
REQ-008 The block SHALL have ports mN_we_i, mN_cyc_i and mN_stb_i, each input, 1 bit: master N write enable, cycle and strobe.
REQ-009 The block SHALL have ports mN_ack_o and mN_err_o, each output, 1 bit: master N acknowledge and error.
REQ-010 The block SHALL have ports s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o and s_stb_o, outputs of width 32/32/4/1/1/1 bits: the shared slave request.
REQ-011 The block SHALL have port s_dat_i, input, 32 bits: slave read data.
REQ-012 The block SHALL have ports s_ack_i and s_err_i, each input, 1 bit: slave acknowledge and error.
REQ-013 The block SHALL have port grant_o, output, 2 bits: one-hot current owner, 00 when idle.

Function
REQ-014 The block SHALL implement the FSM states IDLE, GNT0 and GNT1, together with a last_owner register (1 bit) and a stall counter (16 bits).
REQ-015 In IDLE:
- If only mN_cyc_i=1, the next state SHALL be GNTN.
- If both are 1, the next state SHALL be the master not equal to last_owner (round-robin).
- If neither is 1, the FSM SHALL stay in IDLE.
REQ-016 Grant latency SHALL be exactly 1 cycle: a request sampled in IDLE at edge n SHALL give s_cyc_o=1 in the cycle after edge n.
REQ-017 In GNTN, the s_* request outputs SHALL be combinational copies of the mN_* inputs, and mN_ack_o SHALL equal s_ack_i and mN_err_o SHALL equal s_err_i.
REQ-018 In IDLE, s_cyc_o, s_stb_o and s_we_o SHALL be 0, and s_adr_o, s_dat_o and s_sel_o SHALL be 0.
REQ-019 The non-granted master's ack_o and err_o SHALL be 0; both mN_dat_o SHALL always equal s_dat_i.
REQ-020 The grant SHALL be held for as long as the owner keeps mN_cyc_i=1, including across multiple stb/ack beats; the other master SHALL never be granted mid-cycle.
REQ-021 When the owner samples mN_cyc_i=0:
- the next state SHALL be IDLE;
- last_owner SHALL be set to N;
- at least one idle cycle SHALL follow before any new grant.
REQ-022 Stall counter rules:
- It SHALL clear in IDLE.
- It SHALL clear on any cycle with s_ack_i or s_err_i = 1.
- It SHALL otherwise increment while s_stb_o=1, saturating at 16'hFFFF.
REQ-023 Timeout (TIMEOUT!=0), when counter==TIMEOUT with s_stb_o=1 and no s_ack_i/s_err_i:
- mN_err_o SHALL pulse for exactly 1 cycle;
- s_cyc_o and s_stb_o SHALL be forced 0 in that cycle;
- the next state SHALL be IDLE and last_owner SHALL be set to N.
REQ-024 If the owner still holds cyc after a timeout, it SHALL re-arbitrate as a new request; the other master SHALL win if it is requesting.
REQ-025 A simultaneous s_ack_i and timeout condition SHALL resolve as ack: no err is forwarded and the counter clears.
REQ-026 Bus signals (adr, dat, sel, we) from the non-owner SHALL NOT reach s_* in any state.
REQ-027 grant_o SHALL be 01 in GNT0, 10 in GNT1 and 00 in IDLE.

Reset
REQ-028 On reset=1 at a clock edge:
- state SHALL become IDLE, last_owner SHALL become 1 (so m0 wins the first tie) and the counter SHALL become 0;
- all outputs SHALL take their IDLE values from the following cycle.
REQ-029 Reset asserted mid-transfer SHALL drop s_cyc_o the next cycle with no ack or err forwarded to either master.

Verification
REQ-030 Both masters assert cyc/stb on the same cycle after reset -> grant_o=01 one cycle later; after m0 completes, a dead cycle, then grant_o=10.
REQ-031 m0 performs 4 back-to-back reads (ack each cycle) while m1 requests -> grant_o stays 01 for all 4 beats; m1 is granted only after m0 drops cyc.
REQ-032 With TIMEOUT=8, m1 strobes and the slave never acks -> m1_err_o=1 for one cycle at stall count 8 with s_cyc_o=0 that cycle; state returns to IDLE.
REQ-033 m0 writes adr=32'h4000_0010, dat=32'hDEADBEEF, sel=4'b0011 while m1 drives other values -> s_* show m0's values exactly; m1_ack_o stays 0.
REQ-034 Reset pulsed during a granted m1 transfer -> s_cyc_o=0 and grant_o=00 the next cycle; the next tie is granted to m0.
REQ-035 s_ack_i arrives on the same cycle the counter reaches TIMEOUT -> only ack is forwarded, err stays 0 and the transfer continues.
